health_mon: RTL

HEALTH_MON -- requirements
Module: health_mon

---
 rtl/health_mon.sv | 116 +++++++++++
 1 files changed

// File: rtl/health_mon.sv
// Online health tests (repetition count + adaptive proportion) on DIN[0], with a one-cycle forwarding register.
// Optional HEALTH_GATE_EN: suppress EN from the first failing sample onward until reset.
module health_mon #(
  parameter int unsigned RCT_CUTOFF = 32,
  parameter int unsigned APT_WINDOW = 1024,
  parameter int unsigned APT_CUTOFF = 589
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       WE,
  output logic [7:0] DOUT,
  output logic       EN,
  output logic       RCT_FAIL,
  output logic       APT_FAIL,
  output logic       ALARM
);

  localparam int unsigned RW = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned AW = $clog2(APT_WINDOW + 1);
  localparam logic [RW-1:0] RCT_MAX = RW'(RCT_CUTOFF);
  localparam logic [AW-1:0] APT_WIN = AW'(APT_WINDOW);
  localparam logic [AW-1:0] APT_MAX = AW'(APT_CUTOFF);

  typedef enum logic {APT_IDLE, APT_ACTIVE} apt_state_e;

  apt_state_e    state_q, state_d;
  logic [7:0]    dout_q, dout_d;
  logic          en_q, en_d;
  logic          rct_fail_q, rct_fail_d;
  logic          apt_fail_q, apt_fail_d;
  logic          alarm_q, alarm_d;
  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic [AW-1:0] match_q, match_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ref_q, ref_d;
  logic          smp;

  assign smp = DIN[0];

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    rct_fail_d = rct_fail_q;
    apt_fail_d = apt_fail_q;
    run_d      = run_q;
    last_d     = last_q;
    match_d    = match_q;
    idx_d      = idx_q;
    ref_d      = ref_q;
    if (WE) begin
      dout_d = DIN;
      // run_q == 0 only before the first sample after reset
      if (run_q == '0 || smp != last_q) begin
        run_d  = RW'(1);
        last_d = smp;
      end else if (run_q < RCT_MAX) begin
        run_d = run_q + RW'(1);
      end
      if (run_d == RCT_MAX) rct_fail_d = 1'b1;

      if (state_q == APT_IDLE) begin
        ref_d   = smp;
        match_d = AW'(1);
        idx_d   = AW'(1);
      end else begin
        idx_d = idx_q + AW'(1);
        if (smp == ref_q) match_d = match_q + AW'(1);
      end
      state_d = (idx_d == APT_WIN) ? APT_IDLE : APT_ACTIVE;
      if (match_d == APT_MAX) apt_fail_d = 1'b1;
    end
    alarm_d = rct_fail_d | apt_fail_d;
`ifdef HEALTH_GATE_EN
    en_d = WE & ~(rct_fail_d | apt_fail_d);
`else
    en_d = WE;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= APT_IDLE;
      dout_q     <= '0;
      en_q       <= 1'b0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      alarm_q    <= 1'b0;
      run_q      <= '0;
      last_q     <= 1'b0;
      match_q    <= '0;
      idx_q      <= '0;
      ref_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      en_q       <= en_d;
      rct_fail_q <= rct_fail_d;
      apt_fail_q <= apt_fail_d;
      alarm_q    <= alarm_d;
      run_q      <= run_d;
      last_q     <= last_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      ref_q      <= ref_d;
    end
  end

  assign DOUT     = dout_q;
  assign EN       = en_q;
  assign RCT_FAIL = rct_fail_q;
  assign APT_FAIL = apt_fail_q;
  assign ALARM    = alarm_q;

endmodule
